// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command byte transmitter.
// Open-drain drive of ps2_clk/ps2_data, sharing pins with ps2_keyboard.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES)
                      ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [9:0]    frame_q;
  logic [9:0]    frame_d;
  logic [3:0]    idx_q;
  logic [3:0]    idx_d;
  logic          drv_q;
  logic          drv_d;
  logic          done_d;
  logic          err_d;
  logic [1:0]    code_d;
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic          clk_now;
  logic          data_now;
  logic          fe;
  logic          accept;
  logic          timed;
  logic          timeout;

  assign clk_now  = clk_sync[1];
  assign data_now = data_sync[1];
  assign fe       = clk_prev & ~clk_now;

  assign busy     = (state_q != S_IDLE);
  assign tx_ready = (state_q == S_IDLE) && !tx_done && !tx_err;
  assign accept   = tx_valid && tx_ready;

  assign timed = (state_q == S_REQ) || (state_q == S_SEND) ||
                 (state_q == S_ACK) || (state_q == S_RELEASE);
  assign timeout = timed && (cnt_q == TO_LAST);

  // Start bit goes low on the last inhibit cycle, while clk is still held.
  assign ps2_clk_oe  = (state_q == S_INHIBIT);
  assign ps2_data_oe =
    ((state_q == S_INHIBIT) && (cnt_q == INH_LAST)) ||
    (state_q == S_REQ) ||
    ((state_q == S_SEND) && drv_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    drv_d   = drv_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = err_code;
    if (timeout) begin
      err_d   = 1'b1;
      code_d  = 2'b01;
      drv_d   = 1'b0;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            frame_d = {1'b1, ~^tx_data, tx_data};
            cnt_d   = '0;
            idx_d   = '0;
            drv_d   = 1'b0;
            code_d  = 2'b00;
            state_d = S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            cnt_d   = '0;
            state_d = S_REQ;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_REQ: begin
          cnt_d = cnt_q + CW'(1);
          if (fe) begin
            drv_d   = ~frame_q[0];
            idx_d   = 4'd1;
            state_d = S_SEND;
          end
        end
        S_SEND: begin
          cnt_d = cnt_q + CW'(1);
          if (fe) begin
            drv_d = ~frame_q[idx_q];
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd9) state_d = S_ACK;
          end
        end
        S_ACK: begin
          cnt_d = cnt_q + CW'(1);
          if (fe) begin
            if (!data_now) begin
              state_d = S_RELEASE;
            end else begin
              err_d   = 1'b1;
              code_d  = 2'b10;
              state_d = S_IDLE;
            end
          end
        end
        S_RELEASE: begin
          cnt_d = cnt_q + CW'(1);
          if (clk_now && data_now) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      frame_q   <= '0;
      idx_q     <= '0;
      drv_q     <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
      err_code  <= 2'b00;
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      drv_q     <= drv_d;
      tx_done   <= done_d;
      tx_err    <= err_d;
      err_code  <= code_d;
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model driving the host transmitter.
// Received frames are compared with a frame model built from the byte.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int TO  = 1500;

  localparam int M_NORMAL  = 0;
  localparam int M_NOCLOCK = 1;
  localparam int M_NOACK   = 2;
  localparam int M_ABORT   = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       dev_clk_low;
  logic       dev_data_low;
  logic       ps2_clk_line;
  logic       ps2_data_line;

  always #5 clk = ~clk;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .err_code   (err_code),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         inh_starts = 0;
  int         err_cyc = 0;
  logic [1:0] last_code = 2'b00;
  logic [1:0] err_oe = 2'b00;
  logic       rst_q = 1'b0;
  logic       clk_line_q = 1'b1;
  logic       p_done = 1'b0;
  logic       p_err = 1'b0;
  logic       p_doe = 1'b0;
  logic       p_coe = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Odd parity over the byte, LSB first, framed by start 0 and stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rst_q      <= resetn;
    clk_line_q <= ps2_clk_line;
  end

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_err === 1'b1) begin
      err_cnt++;
      err_cyc   = cyc;
      last_code = err_code;
      err_oe    = {ps2_clk_oe, ps2_data_oe};
    end
    if (ps2_clk_oe === 1'b1 && p_coe === 1'b0) inh_starts++;
    if (rst_q === 1'b1) begin
      check("done_err_excl", {31'd0, tx_done & tx_err}, 0);
      if (busy === 1'b0)
        check("idle_no_drive", {ps2_clk_oe, ps2_data_oe}, 0);
      if (p_done || p_err) begin
        check("pulse_one_cycle", {tx_done, tx_err}, 0);
        check("ready_after_pulse", tx_ready, 1);
      end
      if (ps2_data_oe !== p_doe && tx_err !== 1'b1)
        check("data_change_clk_low", clk_line_q, 0);
    end
    p_done = tx_done;
    p_err  = tx_err;
    p_doe  = ps2_data_oe;
    p_coe  = ps2_clk_oe;
  end

  task automatic device_run(input int mode, input int hp,
                            output logic [10:0] rx, output int t_req);
    int   n;
    logic early;
    logic last;
    rx    = '0;
    t_req = 0;
    n     = 0;
    while (ps2_clk_oe !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (ps2_clk_oe !== 1'b1) begin
      check("inhibit_seen", 0, 1);
      return;
    end
    n     = 0;
    early = 1'b0;
    last  = 1'b0;
    while (ps2_clk_oe === 1'b1 && n < INH + 100) begin
      n++;
      if (n < INH && ps2_data_oe !== 1'b0) early = 1'b1;
      last = ps2_data_oe;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("start_on_last_inhibit", {early, last}, 2'b01);
    check("req_drive", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    t_req = cyc;
    if (mode == M_NOCLOCK) return;
    repeat (5) @(negedge clk);
    rx[0] = ps2_data_line;
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (hp) @(negedge clk);
      if (mode == M_ABORT && i == 4) begin
        check("abort_busy_before", busy, 1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("abort_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", tx_ready, 1);
        @(negedge clk);
        resetn      = 1'b1;
        dev_clk_low = 1'b0;
        repeat (hp) @(negedge clk);
        return;
      end
      dev_clk_low = 1'b0;
      rx[i+1]     = ps2_data_line;
      if (i == 9 && mode == M_NORMAL) begin
        repeat (hp / 2) @(negedge clk);
        dev_data_low = 1'b1;
        repeat (hp - hp / 2) @(negedge clk);
      end else begin
        repeat (hp) @(negedge clk);
      end
    end
    dev_clk_low = 1'b1;
    repeat (hp) @(negedge clk);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (hp) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      check("ready_wait", 0, 1);
      return;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("accept_ready_low", tx_ready, 0);
    check("accept_busy", busy, 1);
    check("accept_clk_drive", ps2_clk_oe, 1);
    check("accept_code_clear", err_code, 0);
  endtask

  task automatic wait_end(input int base, input int budget);
    int n;
    n = 0;
    while (done_cnt + err_cnt <= base && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt + err_cnt <= base) check("end_wait", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_xfer(input logic [7:0] b, input int mode,
                          input int hp, input logic [10:0] exp_rx,
                          input string name);
    int          d0;
    int          e0;
    int          treq;
    logic [10:0] rx;
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      device_run(mode, hp, rx, treq);
      send_byte(b);
    join
    if (mode != M_ABORT) wait_end(d0 + e0, TO + 200);
    if (mode == M_NORMAL) begin
      check({name, "_frame"}, {21'd0, rx}, {21'd0, exp_rx});
      check({name, "_done"}, done_cnt - d0, 1);
      check({name, "_noerr"}, err_cnt - e0, 0);
      check({name, "_ready"}, tx_ready, 1);
    end else if (mode == M_NOACK) begin
      check({name, "_frame"}, {21'd0, rx}, {21'd0, exp_rx});
      check({name, "_err"}, err_cnt - e0, 1);
      check({name, "_nodone"}, done_cnt - d0, 0);
      check({name, "_code"}, last_code, 2'b10);
      check({name, "_code_held"}, err_code, 2'b10);
    end else if (mode == M_NOCLOCK) begin
      check({name, "_err"}, err_cnt - e0, 1);
      check({name, "_code"}, last_code, 2'b01);
      check({name, "_delay"}, err_cyc - treq, TO);
      check({name, "_oe"}, err_oe, 0);
    end else begin
      check({name, "_nodone"}, done_cnt - d0, 0);
      check({name, "_noerr"}, err_cnt - e0, 0);
    end
  endtask

  initial begin
    int          d0;
    int          s0;
    int          treq;
    logic [10:0] rx;
    logic [7:0]  b;
    resetn       = 1'b0;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pulses", {tx_done, tx_err}, 0);
    check("rst_code", err_code, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    run_xfer(8'hED, M_NORMAL, 20, 11'h7DA, "ed");
    run_xfer(8'h00, M_NORMAL, 17, 11'h600, "x00");
    run_xfer(8'hFF, M_NORMAL, 23, 11'h7FE, "xff");
    run_xfer(8'h01, M_NORMAL, 15, 11'h402, "x01");
    run_xfer(8'h12, M_NOCLOCK, 20, 11'h000, "noclk");
    run_xfer(8'h3C, M_NOACK, 19, exp_frame(8'h3C), "noack");
    run_xfer(8'hA5, M_ABORT, 20, 11'h000, "abort");
    run_xfer(8'hF4, M_NORMAL, 21, 11'h5E8, "f4");

    d0 = done_cnt;
    s0 = inh_starts;
    fork
      device_run(M_NORMAL, 20, rx, treq);
      send_byte(8'h55);
      begin
        repeat (INH + 60) @(negedge clk);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_end(d0 + err_cnt, TO + 200);
    repeat (INH + 30) @(negedge clk);
    check("ovl_frame", {21'd0, rx}, {21'd0, 11'h6AA});
    check("ovl_done", done_cnt - d0, 1);
    check("ovl_one_inhibit", inh_starts - s0, 1);
    check("ovl_idle", busy, 0);

    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      run_xfer(b, M_NORMAL, int'($urandom_range(15, 25)),
               exp_frame(b), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
